// File: rtl/bank_copy_master.sv
// bank_copy_master: block-copy initiator for one single-port bank with a one-cycle registered read.
// Block-fill (FILL state, mode, fill_data) is built only when BANK_COPY_FILL_EN is defined.
module bank_copy_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [ADDR_W:0]   i_length,
    input  logic [DATA_W-1:0] i_fill_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_bank_addr,
    output logic [DATA_W-1:0] o_bank_wdata,
    output logic              o_bank_re,
    output logic              o_bank_we,
    input  logic [DATA_W-1:0] i_bank_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_DONE = 3'd3
`ifdef BANK_COPY_FILL_EN
        , S_FILL = 3'd4
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W:0]     r_rem;
    logic                r_busy;
    logic                r_done;
    logic                r_re;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wsel_rd;
    logic [ADDR_W-1:0]   w_src_nxt;
    logic [ADDR_W-1:0]   w_dst_nxt;
    logic [ADDR_W:0]     w_rem_nxt;
    logic [DATA_W-1:0]   w_wdata;

`ifdef BANK_COPY_FILL_EN
    logic                r_wsel_fill;
    logic [DATA_W-1:0]   r_fill_data;

    // Fill pattern is payload only; it is qualified by r_wsel_fill, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && i_start) begin
            r_fill_data <= i_fill_data;
        end
    end
`else
    logic                w_unused_cfg;
    assign w_unused_cfg = ^{i_mode, i_fill_data};
`endif

    assign w_src_nxt = r_src + ADDR_ONE;
    assign w_dst_nxt = r_dst + ADDR_ONE;
    assign w_rem_nxt = r_rem - REM_ONE;

    // Strobes and address are registered alongside the state, so each value describes the current state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_dst     <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wsel_rd <= 1'b0;
`ifdef BANK_COPY_FILL_EN
            r_wsel_fill <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wsel_rd <= 1'b0;
`ifdef BANK_COPY_FILL_EN
            r_wsel_fill <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src  <= i_src_addr;
                        r_dst  <= i_dst_addr;
                        r_rem  <= i_length;
                        r_busy <= 1'b1;
                        if (i_length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
`ifdef BANK_COPY_FILL_EN
                        end else if (i_mode) begin
                            r_state     <= S_FILL;
                            r_addr      <= i_dst_addr;
                            r_we        <= 1'b1;
                            r_wsel_fill <= 1'b1;
`endif
                        end else begin
                            r_state <= S_RD;
                            r_addr  <= i_src_addr;
                            r_re    <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_state   <= S_WR;
                    r_addr    <= r_dst;
                    r_we      <= 1'b1;
                    r_wsel_rd <= 1'b1;
                end
                S_WR: begin
                    r_src <= w_src_nxt;
                    r_dst <= w_dst_nxt;
                    r_rem <= w_rem_nxt;
                    if (r_rem == REM_ONE) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RD;
                        r_addr  <= w_src_nxt;
                        r_re    <= 1'b1;
                    end
                end
`ifdef BANK_COPY_FILL_EN
                S_FILL: begin
                    r_dst <= w_dst_nxt;
                    r_rem <= w_rem_nxt;
                    if (r_rem == REM_ONE) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr      <= w_dst_nxt;
                        r_we        <= 1'b1;
                        r_wsel_fill <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Copy write data is the bank's registered read data passed straight through during WR.
    always_comb begin
        w_wdata = '0;
        if (r_wsel_rd) begin
            w_wdata = i_bank_rdata;
        end
`ifdef BANK_COPY_FILL_EN
        else if (r_wsel_fill) begin
            w_wdata = r_fill_data;
        end
`endif
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_bank_addr  = r_addr;
    assign o_bank_wdata = w_wdata;
    assign o_bank_re    = r_re;
    assign o_bank_we    = r_we;

endmodule

// File: tb/tb_bank_copy_master.sv
// Bench for bank_copy_master: behavioural bank, reference memory model and write/read scoreboards.
// Fill expectations follow BANK_COPY_FILL_EN.
module tb_bank_copy_master;

    localparam int BUDGET = 600;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        logic       mode;
        logic [7:0] fill;
        int         exp_lat;
    } cmd_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_mode;
    logic [7:0] i_src_addr;
    logic [7:0] i_dst_addr;
    logic [8:0] i_length;
    logic [7:0] i_fill_data;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_bank_addr;
    logic [7:0] o_bank_wdata;
    logic       o_bank_re;
    logic       o_bank_we;
    logic [7:0] bank_rdata;

    logic       pl_en;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;
    logic [7:0] bank_mem [256];
    logic [7:0] ref_mem  [256];

    wr_t        exp_wq[$];
    logic [7:0] exp_rq[$];
    int         n_checks;
    int         n_fail;
    cmd_t       tbl[7];

    bank_copy_master #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (i_start),
        .i_mode      (i_mode),
        .i_src_addr  (i_src_addr),
        .i_dst_addr  (i_dst_addr),
        .i_length    (i_length),
        .i_fill_data (i_fill_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bank_addr (o_bank_addr),
        .o_bank_wdata(o_bank_wdata),
        .o_bank_re   (o_bank_re),
        .o_bank_we   (o_bank_we),
        .i_bank_rdata(bank_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port bank with one-cycle registered read; the bench preloads it through pl_*.
    always @(posedge clk) begin
        if (pl_en) bank_mem[pl_addr] <= pl_data;
        else if (o_bank_we) bank_mem[o_bank_addr] <= o_bank_wdata;
        if (o_bank_re) bank_rdata <= bank_mem[o_bank_addr];
    end

    task automatic push_expected(input cmd_t c, input int nacc);
        logic [7:0] s, d, v;
        logic fill_eff;
`ifdef BANK_COPY_FILL_EN
        fill_eff = c.mode;
`else
        fill_eff = 1'b0;
`endif
        s = c.src;
        d = c.dst;
        for (int i = 0; i < nacc; i++) begin
            if (fill_eff) begin
                v = c.fill;
            end else begin
                exp_rq.push_back(s);
                v = ref_mem[s];
            end
            ref_mem[d] = v;
            exp_wq.push_back({d, v});
            s = s + 8'd1;
            d = d + 8'd1;
        end
    endtask

    task automatic step();
        wr_t        e;
        logic [7:0] ra;
        @(negedge clk);
        n_checks++;
        if (o_bank_re && o_bank_we) begin
            n_fail++;
            $display("FAIL strobe_excl re=%0b we=%0b required not both 1", o_bank_re, o_bank_we);
        end
        if (o_bank_we) begin
            n_checks++;
            if (exp_wq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%02h data=%02h required no write", o_bank_addr, o_bank_wdata);
            end else begin
                e = exp_wq.pop_front();
                if ({o_bank_addr, o_bank_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write addr=%02h data=%02h required addr=%02h data=%02h",
                             o_bank_addr, o_bank_wdata, e.addr, e.data);
                end
            end
        end
        if (o_bank_re) begin
            n_checks++;
            if (exp_rq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read addr=%02h required no read", o_bank_addr);
            end else begin
                ra = exp_rq.pop_front();
                if (o_bank_addr !== ra) begin
                    n_fail++;
                    $display("FAIL read addr=%02h required %02h", o_bank_addr, ra);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({o_busy, o_done, o_bank_re, o_bank_we, o_bank_addr, o_bank_wdata} !== 20'h0) begin
            n_fail++;
            $display("FAIL %s busy=%0b done=%0b re=%0b we=%0b addr=%02h wdata=%02h required all 0",
                     name, o_busy, o_done, o_bank_re, o_bank_we, o_bank_addr, o_bank_wdata);
        end
    endtask

    task automatic run_cmd(input string name, input cmd_t c, input int poke_at,
                           input int rst_at, input int nacc);
        int got;
        got = 0;
        push_expected(c, nacc);
        i_src_addr  = c.src;
        i_dst_addr  = c.dst;
        i_length    = c.len;
        i_mode      = c.mode;
        i_fill_data = c.fill;
        i_start     = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            step();
            if (rst_at != 0 && cyc > rst_at) begin
                check_idle_outputs({name, "_after_reset"});
                break;
            end
            if (o_done) begin
                got = cyc;
                break;
            end
            n_checks++;
            if (!o_busy) begin
                n_fail++;
                $display("FAIL %s_busy cycle=%0d busy=%0b required 1", name, cyc, o_busy);
            end
            if (cyc == poke_at) begin
                i_start    = 1'b1;
                i_src_addr = 8'h00;
                i_dst_addr = 8'hC0;
                i_length   = 9'd2;
            end else if (poke_at != 0 && cyc == poke_at + 1) begin
                i_start = 1'b0;
            end
            if (cyc == rst_at) reset = 1'b0;
        end
        if (rst_at == 0) begin
            n_checks++;
            if (got != c.exp_lat) begin
                n_fail++;
                $display("FAIL %s_done_latency got=%0d required=%0d", name, got, c.exp_lat);
            end
            step();
            n_checks++;
            if (o_done || o_busy) begin
                n_fail++;
                $display("FAIL %s_after_done done=%0b busy=%0b required 0 0", name, o_done, o_busy);
            end
        end else begin
            step();
            reset = 1'b1;
            for (int k = 0; k < 12; k++) begin
                step();
                n_checks++;
                if (o_done || o_busy) begin
                    n_fail++;
                    $display("FAIL %s_no_done done=%0b busy=%0b required 0 0", name, o_done, o_busy);
                end
            end
        end
        n_checks++;
        if (exp_wq.size() != 0 || exp_rq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending writes=%0d reads=%0d required 0 0", name, exp_wq.size(), exp_rq.size());
        end
        exp_wq.delete();
        exp_rq.delete();
    endtask

    task automatic compare_bank(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            if (bank_mem[a] !== ref_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_bank words_wrong=%0d first=%02h got=%02h required=%02h",
                     name, bad, first[7:0], bank_mem[first], ref_mem[first]);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    initial begin
        logic [7:0] pat[4];
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        i_start     = 1'b0;
        i_mode      = 1'b0;
        i_src_addr  = '0;
        i_dst_addr  = '0;
        i_length    = '0;
        i_fill_data = '0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;

        tbl[0] = '{8'h10, 8'h80, 9'd4,   1'b0, 8'h00, 9};
        tbl[1] = '{8'hFE, 8'h40, 9'd4,   1'b0, 8'h00, 9};
        tbl[2] = '{8'h05, 8'h06, 9'd0,   1'b0, 8'h00, 1};
        tbl[3] = '{8'h20, 8'h90, 9'd256, 1'b0, 8'h00, 513};
        tbl[4] = '{8'h50, 8'h52, 9'd6,   1'b0, 8'h00, 13};
`ifdef BANK_COPY_FILL_EN
        tbl[5] = '{8'h30, 8'hFC, 9'd8,   1'b1, 8'h5A, 9};
`else
        tbl[5] = '{8'h30, 8'hFC, 9'd8,   1'b1, 8'h5A, 17};
`endif
        tbl[6] = '{8'h00, 8'hFF, 9'd1,   1'b0, 8'h00, 3};

        repeat (2) @(negedge clk);
        check_idle_outputs("reset_state");
        reset = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 256; a++) preload(a[7:0], 8'($urandom));
        for (int i = 0; i < 4; i++) preload(8'h10 + 8'(i), pat[i]);

        for (int t = 0; t < 7; t++) begin
            run_cmd($sformatf("vec%0d", t), tbl[t], 0, 0, int'(tbl[t].len));
            compare_bank($sformatf("vec%0d", t));
            if (t == 0) begin
                for (int i = 0; i < 4; i++) begin
                    n_checks++;
                    if (bank_mem[8'h80 + i] !== pat[i]) begin
                        n_fail++;
                        $display("FAIL vec0_dst%0d got=%02h required=%02h", i, bank_mem[8'h80 + i], pat[i]);
                    end
                end
            end
        end

        run_cmd("start_while_busy", '{8'h60, 8'hA0, 9'd4, 1'b0, 8'h00, 9}, 3, 0, 4);
        compare_bank("start_while_busy");

        run_cmd("reset_mid", '{8'h70, 8'hB0, 9'd4, 1'b0, 8'h00, 9}, 0, 4, 2);
        compare_bank("reset_mid");

        run_cmd("post_reset", '{8'hC8, 8'h08, 9'd3, 1'b0, 8'h00, 7}, 0, 0, 3);
        compare_bank("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_copy_master.md
# bank_copy_master

Initiator for one single-port data bank: executes block-copy (and optionally block-fill) commands by driving the bank's addr / data_in / read_enable / write_enable port and consuming its registered read data. Sits between the control unit (command side) and a bank instance (memory side); it is the only master of that bank port while busy.

## Interface
- ADDR_W, 8, bank word-address width (bank depth 2^ADDR_W = 256)
- DATA_W, 8, bank word width
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-low; clock clk
- start  input  1  command strobe, sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill (fill only with BANK_COPY_FILL_EN)
- src_addr  input  ADDR_W  copy source start address
- dst_addr  input  ADDR_W  destination start address
- length  input  ADDR_W+1  word count, 0..2^ADDR_W
- fill_data  input  DATA_W  fill pattern
- busy  output  1  command in progress (state != IDLE)
- done  output  1  one-cycle completion pulse
- bank_addr  output  ADDR_W  to bank addr
- bank_wdata  output  DATA_W  to bank data_in
- bank_re  output  1  to bank read_enable
- bank_we  output  1  to bank write_enable
- bank_rdata  input  DATA_W  from bank data_out (valid the cycle after bank_re)

## Operation
- States: IDLE, RD, WR, FILL, DONE. Moore outputs decoded from registered state/counters.
- IDLE: start=1 latches src, dst, length, mode, fill_data; length=0 -> DONE; mode=0 -> RD; mode=1 -> FILL (or RD if fill compiled out, i.e. mode ignored).
- RD: bank_addr=src_cnt, bank_re=1, bank_we=0; -> WR.
- WR: bank_addr=dst_cnt, bank_wdata=bank_rdata (combinational pass-through), bank_we=1, bank_re=0; src_cnt++, dst_cnt++, remaining--; remaining reaches 0 -> DONE else -> RD.
- FILL: bank_addr=dst_cnt, bank_wdata=fill_data latched, bank_we=1; dst_cnt++, remaining--; 0 -> DONE.
- DONE: done=1, all bank strobes 0; -> IDLE.
- Address counters ADDR_W wide, wrap 2^ADDR_W-1 -> 0. Remaining counter ADDR_W+1 wide; length 256 copies full bank.
- Overlap: strictly ascending word order; dst in (src, src+len) overwrites unread source — defined behaviour, not corrected.
- start while busy ignored; command inputs not sampled outside IDLE.
- bank_re and bank_we never both 1. Idle outputs: bank_addr=0, bank_wdata=0, strobes 0.

## Timing
- Reset (reset=0 at posedge): state IDLE, counters 0; busy=0, done=0, bank_re=0, bank_we=0, bank_addr=0, bank_wdata=0 from next cycle.
- Reset mid-command: aborts immediately, no further bank accesses; partial writes stay in bank; no done pulse.
- Start sampled at edge T: first access cycle T+1.
- Copy of N words: 2N access cycles (RD/WR alternating), done high in cycle T+2N+1, busy low at T+2N+2; next start accepted in IDLE cycle T+2N+2.
- Fill of N words: N cycles, done at T+N+1.
- length=0: done at T+1, no bank strobes.
- Read data relies on bank's one-cycle registered read; bank_rdata is consumed only in WR.

## Configuration
- BANK_COPY_FILL_EN defined: FILL state, mode and fill_data active.
- Undefined: FILL state and fill_data register not built; mode ignored, every command is a copy; fill_data input left unconnected internally.

## Test plan
- Preload bank[0x10..0x13]=A1,B2,C3,D4; copy src=0x10 dst=0x80 len=4 -> bank[0x80..0x83]=A1,B2,C3,D4, done exactly 9 cycles after start edge, strobes alternate re/we.
- Copy src=0xFE dst=0x40 len=4 -> reads 0xFE,0xFF,0x00,0x01 (wrap), bank[0x40..0x43] matches.
- length=0 -> done at T+1, no bank_re/bank_we ever asserted; length=256 -> full-bank copy, done at T+513.
- start pulsed again at T+3 of a len=4 copy -> ignored, single done pulse, bank unchanged beyond dst range.
- reset=0 asserted at T+4 of len=4 copy -> outputs zero next cycle, only dst[0] (and dst[1] if WR completed) written, no done.
- With BANK_COPY_FILL_EN: mode=1 fill_data=0x5A dst=0xFC len=8 -> bank[0xFC..0x03]=5A, done at T+9; without macro same command performs copy from src_addr.
